// File: rtl/gpu_fb_pkg.sv
// Shared types and widths for the framebuffer arbiter: pixel layout, read-owner tags
// and double-buffer swap states.
package gpu_fb_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_BLEND = 2'd1,
        OWN_SCAN  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        SW_IDLE    = 2'd0,
        SW_PENDING = 2'd1,
        SW_DRAIN   = 2'd2
    } swap_state_t;

endpackage

// File: rtl/fb_arbiter_rd_tag_pipe.sv
// Owner-tag delay line matching the SRAM read latency; the output stage names who
// receives mem_rdata in the current cycle.
module rd_tag_pipe
    import gpu_fb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  owner_t tag_in,
    output owner_t tag_out,
    output logic   any_busy
);

    owner_t stage_reg [RD_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg[0] <= OWN_NONE;
        end else begin
            stage_reg[0] <= tag_in;
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stage_reg[gi] <= OWN_NONE;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign tag_out = stage_reg[RD_LAT-1];

    always_comb begin
        any_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (stage_reg[i] != OWN_NONE) begin
                any_busy = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer SRAM arbiter between the alpha blender and scanout, with
// vblank-synchronised front/back buffer swapping.
module fb_arbiter #(
    parameter int ADDR_W     = gpu_fb_pkg::ADDR_W,
    parameter int DATA_W     = gpu_fb_pkg::DATA_W,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blend_read,
    input  logic              blend_write,
    input  logic [ADDR_W-1:0] blend_addr,
    input  logic [DATA_W-1:0] blend_wdata,
    output logic              blend_gnt,
    output logic [DATA_W-1:0] blend_rdata,
    output logic              blend_rvalid,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              scan_urgent,
    output logic              scan_gnt,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              frame_ready,
    input  logic              vblank,
    output logic              front_sel,
    output logic              swap_done
);
    import gpu_fb_pkg::*;

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    swap_state_t         swap_state_reg;
    logic                front_sel_reg;
    logic                swap_done_reg;
    logic [STARVE_W-1:0] starve_reg;
    logic [STARVE_W-1:0] starve_next;

    logic   blend_pending;
    logic   swap_pending;
    logic   grant_blend;
    logic   grant_scan;
    owner_t tag_push;
    owner_t tag_out;
    logic   pipe_busy;

    assign blend_pending = blend_read | blend_write;
    assign swap_pending  = (swap_state_reg != SW_IDLE);

    // Grants are gated by reset so every output drops asynchronously with it.
    always_comb begin
        grant_blend = 1'b0;
        grant_scan  = 1'b0;
        if (reset) begin
            if (blend_pending && starve_reg == STARVE_LIM && !swap_pending) begin
                grant_blend = 1'b1;
            end else if (scan_req && scan_urgent) begin
                grant_scan = 1'b1;
            end else if (blend_pending && !swap_pending) begin
                grant_blend = 1'b1;
            end else if (scan_req) begin
                grant_scan = 1'b1;
            end
        end
    end

    assign blend_gnt = grant_blend;
    assign scan_gnt  = grant_scan;
    assign mem_en    = grant_blend | grant_scan;
    assign mem_we    = grant_blend & blend_write;
    assign mem_wdata = mem_we ? blend_wdata : '0;

    // Blender always touches the back buffer, scanout the front buffer.
    always_comb begin
        mem_addr = '0;
        if (grant_blend) begin
            mem_addr = {~front_sel_reg, blend_addr};
        end else if (grant_scan) begin
            mem_addr = {front_sel_reg, scan_addr};
        end
    end

    always_comb begin
        tag_push = OWN_NONE;
        if (grant_blend && !blend_write) begin
            tag_push = OWN_BLEND;
        end else if (grant_scan) begin
            tag_push = OWN_SCAN;
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (grant_blend || !blend_pending) begin
            starve_next = '0;
        end else if (grant_scan && starve_reg < STARVE_LIM) begin
            starve_next = starve_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .tag_in   (tag_push),
        .tag_out  (tag_out),
        .any_busy (pipe_busy)
    );

    assign blend_rvalid = (tag_out == OWN_BLEND);
    assign scan_rvalid  = (tag_out == OWN_SCAN);
    assign blend_rdata  = blend_rvalid ? mem_rdata : '0;
    assign scan_rdata   = scan_rvalid ? mem_rdata : '0;

    // The flip waits for an empty pipe and an idle port so no access straddles it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_state_reg <= SW_IDLE;
            front_sel_reg  <= 1'b0;
            swap_done_reg  <= 1'b0;
        end else begin
            swap_done_reg <= 1'b0;
            case (swap_state_reg)
                SW_IDLE: begin
                    if (frame_ready) begin
                        swap_state_reg <= SW_PENDING;
                    end
                end
                SW_PENDING: begin
                    if (vblank) begin
                        swap_state_reg <= SW_DRAIN;
                    end
                end
                SW_DRAIN: begin
                    if (!pipe_busy && !mem_en) begin
                        front_sel_reg  <= ~front_sel_reg;
                        swap_done_reg  <= 1'b1;
                        swap_state_reg <= SW_IDLE;
                    end
                end
                default: swap_state_reg <= SW_IDLE;
            endcase
        end
    end

    assign front_sel = front_sel_reg;
    assign swap_done = swap_done_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: arbitration, starvation guard, read return and swap.
module tb_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              blend_read, blend_write;
    logic [ADDR_W-1:0] blend_addr;
    logic [DATA_W-1:0] blend_wdata;
    logic              blend_gnt;
    logic [DATA_W-1:0] blend_rdata;
    logic              blend_rvalid;
    logic              scan_req, scan_urgent;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_gnt;
    logic [DATA_W-1:0] scan_rdata;
    logic              scan_rvalid;
    logic              mem_en, mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              frame_ready, vblank;
    logic              front_sel, swap_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (2),
        .STARVE_MAX (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .blend_read   (blend_read),
        .blend_write  (blend_write),
        .blend_addr   (blend_addr),
        .blend_wdata  (blend_wdata),
        .blend_gnt    (blend_gnt),
        .blend_rdata  (blend_rdata),
        .blend_rvalid (blend_rvalid),
        .scan_req     (scan_req),
        .scan_addr    (scan_addr),
        .scan_urgent  (scan_urgent),
        .scan_gnt     (scan_gnt),
        .scan_rdata   (scan_rdata),
        .scan_rvalid  (scan_rvalid),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .frame_ready  (frame_ready),
        .vblank       (vblank),
        .front_sel    (front_sel),
        .swap_done    (swap_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, well before the next edge.
    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b0;
        blend_read = 0; blend_write = 0; blend_addr = '0; blend_wdata = '0;
        scan_req = 0; scan_urgent = 0; scan_addr = '0;
        mem_rdata = '0; frame_ready = 0; vblank = 0;

        // Reset: requests present but nothing granted, all outputs low
        blend_read = 1;
        #2;
        check("rst_blend_gnt", 32'(blend_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_front_sel", 32'(front_sel), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        check("rst_rvalid", 32'({blend_rvalid, scan_rvalid}), 32'd0);
        blend_read = 0;
        step();
        step();
        reset = 1'b1;
        $display("reset released");

        // Blender read addr 5 -> back buffer {1,5}, data returns 2 cycles later
        step();
        blend_read = 1; blend_addr = 19'd5;
        settle();
        $display("blend read addr=5 gnt=%0d mem_addr=%h", blend_gnt, mem_addr);
        check("rd_gnt", 32'(blend_gnt), 32'd1);
        check("rd_mem_addr", 32'(mem_addr), 32'h80005);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        step();
        blend_read = 0;
        settle();
        check("rd_early_rvalid", 32'(blend_rvalid), 32'd0);
        step();
        mem_rdata = 24'h010203;
        settle();
        $display("blend read return rvalid=%0d rdata=%h", blend_rvalid, blend_rdata);
        check("rd_rvalid", 32'(blend_rvalid), 32'd1);
        check("rd_rdata", 32'(blend_rdata), 32'h010203);
        check("rd_scan_rvalid", 32'(scan_rvalid), 32'd0);
        step();
        mem_rdata = '0;
        settle();
        check("rd_rvalid_pulse", 32'(blend_rvalid), 32'd0);

        // Read and write together: write first, read next cycle
        step();
        blend_read = 1; blend_write = 1; blend_addr = 19'd5; blend_wdata = 24'h09060F;
        settle();
        $display("blend rw: write gnt=%0d we=%0d wdata=%h", blend_gnt, mem_we, mem_wdata);
        check("rw_wr_gnt", 32'(blend_gnt), 32'd1);
        check("rw_wr_we", 32'(mem_we), 32'd1);
        check("rw_wr_wdata", 32'(mem_wdata), 32'h09060F);
        check("rw_wr_addr", 32'(mem_addr), 32'h80005);
        step();
        blend_write = 0;
        settle();
        $display("blend rw: read gnt=%0d we=%0d", blend_gnt, mem_we);
        check("rw_rd_gnt", 32'(blend_gnt), 32'd1);
        check("rw_rd_we", 32'(mem_we), 32'd0);
        step();
        blend_read = 0;
        settle();
        check("rw_idle", 32'(mem_en), 32'd0);

        // Urgent scan vs held blend write: blender wins every 9th cycle
        for (int i = 0; i < 20; i++) begin
            step();
            scan_req = 1; scan_urgent = 1; scan_addr = 19'(i);
            blend_write = 1; blend_addr = 19'(100 + i); blend_wdata = 24'(i);
            settle();
            $display("starve cycle %0d blend_gnt=%0d scan_gnt=%0d", i, blend_gnt, scan_gnt);
            check("starve_blend_gnt", 32'(blend_gnt), (i == 8 || i == 17) ? 32'd1 : 32'd0);
            check("starve_scan_gnt", 32'(scan_gnt), (i == 8 || i == 17) ? 32'd0 : 32'd1);
        end
        step();
        scan_req = 0; scan_urgent = 0; blend_write = 0;

        // Non-urgent scan loses to blender, then wins once blender drops
        step();
        scan_req = 1; scan_addr = 19'd7; blend_read = 1; blend_addr = 19'd8;
        settle();
        $display("non-urgent: blend_gnt=%0d scan_gnt=%0d", blend_gnt, scan_gnt);
        check("nu_blend_gnt", 32'(blend_gnt), 32'd1);
        check("nu_scan_wait", 32'(scan_gnt), 32'd0);
        step();
        blend_read = 0;
        settle();
        $display("non-urgent: scan_gnt=%0d mem_addr=%h", scan_gnt, mem_addr);
        check("nu_scan_gnt", 32'(scan_gnt), 32'd1);
        check("nu_scan_addr", 32'(mem_addr), 32'h00007);
        step();
        scan_req = 0;
        step();
        step();
        step();

        // Swap: frame_ready while vblank=0 blocks the blender
        frame_ready = 1;
        step();
        frame_ready = 0;
        blend_write = 1; blend_addr = 19'd9; blend_wdata = 24'h0A0B0C;
        settle();
        $display("pending: blend_gnt=%0d", blend_gnt);
        check("pend_blocked", 32'(blend_gnt), 32'd0);
        check("pend_mem_en", 32'(mem_en), 32'd0);
        step();
        settle();
        check("pend_blocked2", 32'(blend_gnt), 32'd0);
        step();
        vblank = 1; scan_req = 1; scan_addr = 19'd10;
        settle();
        $display("drain scan A gnt=%0d mem_addr=%h", scan_gnt, mem_addr);
        check("sw_scanA_gnt", 32'(scan_gnt), 32'd1);
        check("sw_scanA_addr", 32'(mem_addr), 32'h0000A);
        step();
        scan_addr = 19'd11;
        settle();
        check("sw_scanB_gnt", 32'(scan_gnt), 32'd1);
        step();
        scan_req = 0; vblank = 0; mem_rdata = 24'h111111;
        settle();
        $display("drain ret A rvalid=%0d rdata=%h", scan_rvalid, scan_rdata);
        check("sw_retA_rvalid", 32'(scan_rvalid), 32'd1);
        check("sw_retA_rdata", 32'(scan_rdata), 32'h111111);
        check("sw_retA_nodone", 32'(swap_done), 32'd0);
        check("sw_retA_blocked", 32'(blend_gnt), 32'd0);
        step();
        mem_rdata = 24'h222222;
        settle();
        $display("drain ret B rvalid=%0d rdata=%h", scan_rvalid, scan_rdata);
        check("sw_retB_rvalid", 32'(scan_rvalid), 32'd1);
        check("sw_retB_rdata", 32'(scan_rdata), 32'h222222);
        check("sw_retB_front", 32'(front_sel), 32'd0);
        step();
        mem_rdata = '0;
        settle();
        check("sw_empty_nodone", 32'(swap_done), 32'd0);
        check("sw_empty_front", 32'(front_sel), 32'd0);
        check("sw_empty_rvalid", 32'(scan_rvalid), 32'd0);
        step();
        settle();
        $display("swap: swap_done=%0d front_sel=%0d blend_gnt=%0d mem_addr=%h",
                 swap_done, front_sel, blend_gnt, mem_addr);
        check("sw_done", 32'(swap_done), 32'd1);
        check("sw_front", 32'(front_sel), 32'd1);
        check("sw_blend_gnt", 32'(blend_gnt), 32'd1);
        check("sw_blend_addr", 32'(mem_addr), 32'h00009);
        check("sw_blend_wdata", 32'(mem_wdata), 32'h0A0B0C);
        step();
        blend_write = 0;
        settle();
        check("sw_done_pulse", 32'(swap_done), 32'd0);
        check("sw_front_hold", 32'(front_sel), 32'd1);

        // Reset asserted mid-DRAIN with two scan reads in flight
        step();
        frame_ready = 1;
        step();
        frame_ready = 0; vblank = 1; scan_req = 1; scan_addr = 19'd3;
        settle();
        check("mr_scan_addr", 32'(mem_addr), 32'h80003);
        step();
        scan_addr = 19'd4;
        settle();
        check("mr_scan2_gnt", 32'(scan_gnt), 32'd1);
        step();
        scan_req = 0; mem_rdata = 24'h333333; blend_read = 1;
        #1;
        reset = 1'b0;
        #1;
        $display("mid-drain reset: front_sel=%0d scan_rvalid=%0d mem_en=%0d",
                 front_sel, scan_rvalid, mem_en);
        check("mr_front", 32'(front_sel), 32'd0);
        check("mr_rvalid", 32'({blend_rvalid, scan_rvalid}), 32'd0);
        check("mr_mem_en", 32'(mem_en), 32'd0);
        check("mr_blend_gnt", 32'(blend_gnt), 32'd0);
        check("mr_scan_rdata", 32'(scan_rdata), 32'd0);
        step();
        step();
        blend_read = 0; vblank = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("mr_post_rvalid", 32'({blend_rvalid, scan_rvalid}), 32'd0);
            check("mr_post_front", 32'(front_sel), 32'd0);
            check("mr_post_done", 32'(swap_done), 32'd0);
            step();
        end
        blend_write = 1; blend_addr = 19'd6; blend_wdata = 24'h123456;
        settle();
        $display("post-reset write gnt=%0d mem_addr=%h", blend_gnt, mem_addr);
        check("mr_idle_gnt", 32'(blend_gnt), 32'd1);
        check("mr_idle_addr", 32'(mem_addr), 32'h80006);
        step();
        blend_write = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
